// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO registers.
// Results are computed at issue and committed after a fixed busy period.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  input  logic        ReadHI,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   hi_q, lo_q, hi_n, lo_n;
  logic [31:0]   hi_tmp, lo_tmp, hi_tmp_n, lo_tmp_n;
  logic          wr, wr_n;

  logic          is_mul, is_div, sgn;
  logic [63:0]   a_ext, b_ext, prod;
  logic [31:0]   a_mag, b_mag, dvsr;
  logic [31:0]   q_mag, r_mag, quo, rem;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    sgn    = 1'b0;
    case (MDOp)
      3'd1: begin is_mul = 1'b1; sgn = 1'b1; end
      3'd2: is_mul = 1'b1;
      3'd3: begin is_div = 1'b1; sgn = 1'b1; end
      3'd4: is_div = 1'b1;
      default: ;
    endcase
  end

  // Sign-extend to 64 bits so one unsigned multiply covers both forms.
  assign a_ext = {{32{sgn & A[31]}}, A};
  assign b_ext = {{32{sgn & B[31]}}, B};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes; fixes up 0x80000000 / -1 without overflow.
  assign a_mag = (sgn && A[31]) ? (~A + 32'd1) : A;
  assign b_mag = (sgn && B[31]) ? (~B + 32'd1) : B;
  assign dvsr  = (B == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / dvsr;
  assign r_mag = a_mag % dvsr;
  assign quo   = (sgn && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = (sgn && A[31]) ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_n     = hi_q;
    lo_n     = lo_q;
    hi_tmp_n = hi_tmp;
    lo_tmp_n = lo_tmp;
    wr_n     = wr;
    unique case (state)
      IDLE: begin
        if (Start && is_mul) begin
          hi_tmp_n = prod[63:32];
          lo_tmp_n = prod[31:0];
          wr_n     = 1'b1;
          cnt_n    = CW'(MULT_CYCLES);
          state_n  = BUSY;
        end else if (Start && is_div) begin
          hi_tmp_n = rem;
          lo_tmp_n = quo;
          wr_n     = (B != 32'd0);
          cnt_n    = CW'(DIV_CYCLES);
          state_n  = BUSY;
        end else if (MDOp == 3'd5) begin
          hi_n = A;
        end else if (MDOp == 3'd6) begin
          lo_n = A;
        end
      end
      BUSY: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          if (wr) begin
            hi_n = hi_tmp;
            lo_n = lo_tmp;
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      wr     <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      hi_tmp <= hi_tmp_n;
      lo_tmp <= lo_tmp_n;
      wr     <= wr_n;
    end
  end

  assign Busy  = (state == BUSY);
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign MDOut = ReadHI ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Random + directed bench for mult_div_unit against a cycle-deadline model.
// Per-cycle compare at negedge; literal checks pin the arithmetic.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  MDOp = '0;
  logic        Start = 1'b0;
  logic        ReadHI = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO, MDOut;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp),
    .Start(Start), .ReadHI(ReadHI), .Busy(Busy),
    .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // {valid, hi, lo}; valid=0 means divide by zero (no write).
  function automatic logic [64:0] ref_op(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    int sa, sb;
    longint la, lb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0] v;
    sa = a; sb = b;
    la = sa; lb = sb;
    ua = {32'd0, a}; ub = {32'd0, b};
    v = '0;
    case (op)
      3'd1: begin p = la * lb; v = p; end
      3'd2: begin p = ua * ub; v = p; end
      3'd3: begin
        if (b == 0) return {1'b0, 64'd0};
        q = la / lb; r = la % lb;
        v = {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return {1'b0, 64'd0};
        p = ua / ub; v[31:0] = p[31:0];
        p = ua % ub; v[63:32] = p[31:0];
      end
      default: ;
    endcase
    return {1'b1, v};
  endfunction

  longint      cyc = 0;
  longint      m_done = 0;
  logic        m_busy = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_wr = 1'b0;
  logic        armed = 1'b0;

  always @(posedge clk) begin
    logic [64:0] r;
    cyc <= cyc + 1;
    armed <= 1'b1;
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0;
    end else if (m_busy) begin
      if (cyc == m_done) begin
        m_busy <= 1'b0;
        if (p_wr) begin m_hi <= p_hi; m_lo <= p_lo; end
      end
    end else if (Start && MDOp >= 3'd1 && MDOp <= 3'd4) begin
      r = ref_op(MDOp, A, B);
      p_wr <= r[64]; p_hi <= r[63:32]; p_lo <= r[31:0];
      m_busy <= 1'b1;
      m_done <= cyc + ((MDOp <= 3'd2) ? MC : DC);
    end else if (MDOp == 3'd5) begin
      m_hi <= A;
    end else if (MDOp == 3'd6) begin
      m_lo <= A;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", {31'd0, Busy}, {31'd0, m_busy});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
      check("mdout", MDOut, ReadHI ? m_hi : m_lo);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic st,
                       input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; MDOp = op; Start = st;
    step(1);
    Start = 1'b0; MDOp = 3'd0;
  endtask

  task automatic busy_len(input string name, input int exp);
    int n = 0;
    while (Busy && n < 60) begin n++; step(1); end
    check(name, n, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    step(2);
    reset = 1'b0;
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    check("reset_busy", {31'd0, Busy}, 32'd0);

    issue(3'd1, 1'b1, 32'hFFFFFFFE, 32'd3);
    busy_len("mult_len", MC);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFA);

    issue(3'd2, 1'b1, 32'hFFFFFFFE, 32'd3);
    busy_len("multu_len", MC);
    check("multu_hi", HI, 32'h00000002);
    check("multu_lo", LO, 32'hFFFFFFFA);

    issue(3'd3, 1'b1, 32'hFFFFFFF9, 32'd2);
    busy_len("div_len", DC);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    issue(3'd4, 1'b1, 32'd7, 32'd2);
    busy_len("divu_len", DC);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    issue(3'd3, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    busy_len("ovf_len", DC);
    check("ovf_lo", LO, 32'h80000000);
    check("ovf_hi", HI, 32'h0);

    issue(3'd5, 1'b0, 32'h11, 32'd0);
    issue(3'd6, 1'b0, 32'h22, 32'd0);
    issue(3'd3, 1'b1, 32'd99, 32'd0);
    busy_len("dz_len", DC);
    check("dz_hi", HI, 32'h11);
    check("dz_lo", LO, 32'h22);

    issue(3'd5, 1'b0, 32'h12345678, 32'd0);
    check("mthi_hi", HI, 32'h12345678);
    issue(3'd6, 1'b1, 32'h9ABCDEF0, 32'd0);
    check("mtlo_lo", LO, 32'h9ABCDEF0);
    check("mt_busy", {31'd0, Busy}, 32'd0);
    ReadHI = 1'b1; #1;
    check("mdout_hi", MDOut, 32'h12345678);
    ReadHI = 1'b0; #1;
    check("mdout_lo", MDOut, 32'h9ABCDEF0);

    issue(3'd4, 1'b1, 32'd100, 32'd7);
    step(1);
    issue(3'd1, 1'b1, 32'd5, 32'd5);
    issue(3'd6, 1'b0, 32'hDEADBEEF, 32'd0);
    busy_len("ign_len", DC - 3);
    check("ign_lo", LO, 32'd14);
    check("ign_hi", HI, 32'd2);

    issue(3'd3, 1'b1, 32'd1000, 32'd3);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    issue(3'd1, 1'b1, 32'd6, 32'd7);
    busy_len("rst_mult_len", MC);
    check("rst_mult_lo", LO, 32'd42);

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: rb = $urandom_range(1, 9);
        default: ;
      endcase
      rop = 3'($urandom_range(0, 7));
      ReadHI = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 60) == 0);
      issue(rop, 1'($urandom_range(0, 3) != 0), ra, rb);
      reset = 1'b0;
    end
    step(DC + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
